alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  D->E issue stage that feeds the E-stage ALU. Decodes the D-stage instruction into
//  the 32-bit ALUop code and ALU operands (A, B, PC, instr), then registers them into
//  the E stage. Handles hazard-unit stall/flush bubbles and E-stage hold.
//  Also keeps a saturating bubble counter for performance debug.
// PARAMETERS
//  CNT_W    16   width of bubble counter (saturating)
//  RESET_PC 32'h0000_3000  e_PC value at reset and in bubbles
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-low reset (asserted when 0)
//  d_valid    in   1   D-stage slot holds a real instruction
//  d_instr    in   32  D-stage instruction word
//  d_PC       in   32  D-stage PC
//  d_rs_data  in   32  forwarded GPR[rs]
//  d_rt_data  in   32  forwarded GPR[rt]
//  stall      in   1   hazard unit: D frozen, bubble into E
//  flush      in   1   squash D instruction, bubble into E
//  e_hold     in   1   E stage frozen; all E registers keep their value
//  e_valid    out  1   E slot holds a real instruction
//  e_A        out  32  ALU operand A
//  e_B        out  32  ALU operand B
//  e_PC       out  32  ALU PC input
//  e_instr    out  32  instruction in E
//  e_ALUop    out  32  ALU op: 0 add, 1 sub, 2 or, 3 lui(B<<16), 4 PC+8
//  e_wreg     out  5   destination GPR (0 = no write)
//  e_illegal  out  1   decoded opcode/funct not supported
//  bubble_cnt out  CNT_W  count of bubble cycles loaded into E
// BEHAVIOUR
//  Reset (reset==0 at posedge): e_valid=0, e_A=e_B=0, e_instr=0, e_ALUop=0, e_wreg=0,
//    e_illegal=0, e_PC=RESET_PC, bubble_cnt=0. Overrides all other inputs.
//  Decode (combinational from d_instr), imm=instr[15:0]:
//    R op=0 funct 0x21 addu: ALUop 0, A=rs, B=rt, wreg=rd
//    R op=0 funct 0x23 subu: ALUop 1, A=rs, B=rt, wreg=rd
//    R op=0 funct 0x00 (incl. nop 0x0): ALUop 0, A=0, B=0, wreg=0
//    ori 0x0D: ALUop 2, A=rs, B=zext(imm), wreg=rt
//    lui 0x0F: ALUop 3, A=0, B=zext(imm), wreg=rt
//    lw  0x23: ALUop 0, A=rs, B=sext(imm), wreg=rt
//    sw  0x2B: ALUop 0, A=rs, B=sext(imm), wreg=0
//    beq 0x04: ALUop 1, A=rs, B=rt, wreg=0
//    jal 0x03: ALUop 4, A=0, B=0, wreg=31
//    other: ALUop 0, A=B=0, wreg=0, illegal=1
//  Per posedge, priority: reset > e_hold > (stall|flush|!d_valid) > load.
//    e_hold: every E register and bubble_cnt unchanged, even if stall/flush high.
//    bubble: e_valid=0, e_instr=0, e_ALUop=0, e_A=e_B=0, e_wreg=0, e_illegal=0,
//      e_PC=RESET_PC; bubble_cnt+=1, saturating at all-ones (no wrap).
//    load: e_valid=1, decoded fields registered, e_PC=d_PC, e_instr=d_instr.
//  Latency: exactly 1 cycle D->E. No combinational path from inputs to outputs.
//  stall and flush together: single bubble, counter +1 once.
//  Illegal instruction still loads with e_valid=1, e_illegal=1, wreg=0.
// TESTING
//  Reset low 2 cycles, d_valid=1 addu -> all outputs reset values, e_PC=0x3000.
//  addu $3,$1,$2 (0x00221821), rs=5, rt=7, PC=0x3004 -> next cycle e_ALUop=0,
//    e_A=5, e_B=7, e_wreg=3, e_valid=1, e_PC=0x3004.
//  lw $4,-4($1) (0x8C24FFFC) -> e_B=0xFFFFFFFC; lui $5,0x1234 -> e_ALUop=3,
//    e_B=0x00001234; jal at PC 0x3010 -> e_ALUop=4, e_PC=0x3010, e_wreg=31.
//  stall=1 for 3 cycles then flush=1 with stall=1 -> 4 bubbles, bubble_cnt=4, e_valid=0.
//  Load ori, then e_hold=1 with stall=1 for 2 cycles -> E unchanged, bubble_cnt unchanged.
//  Preload bubble_cnt to 0xFFFF (CNT_W=16), stall once -> stays 0xFFFF;
//    opcode 0x3F -> e_illegal=1, e_wreg=0.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
// Bundles the D-stage inputs, hazard controls and E-stage outputs of the ALU
// issue stage.
//   slave  : the issue stage (consumes d_*/stall/flush/e_hold, drives e_*)
//   master : the pipeline / test environment (drives d_*/stall/flush/e_hold)
// Signals:
//   d_valid, d_instr, d_PC, d_rs_data, d_rt_data  D-stage slot contents
//   stall, flush                                  hazard-unit bubble requests
//   e_hold                                        freeze the whole E stage
//   e_valid, e_A, e_B, e_PC, e_instr, e_ALUop,
//   e_wreg, e_illegal                             registered E-stage slot
//   bubble_cnt                                    saturating bubble counter
// -----------------------------------------------------------------------------
interface alu_issue_stage_if #(
    parameter int CNT_W = 16
);
    logic             d_valid;
    logic [31:0]      d_instr;
    logic [31:0]      d_PC;
    logic [31:0]      d_rs_data;
    logic [31:0]      d_rt_data;
    logic             stall;
    logic             flush;
    logic             e_hold;

    logic             e_valid;
    logic [31:0]      e_A;
    logic [31:0]      e_B;
    logic [31:0]      e_PC;
    logic [31:0]      e_instr;
    logic [31:0]      e_ALUop;
    logic [4:0]       e_wreg;
    logic             e_illegal;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output d_valid, d_instr, d_PC, d_rs_data, d_rt_data, stall, flush, e_hold,
        input  e_valid, e_A, e_B, e_PC, e_instr, e_ALUop, e_wreg, e_illegal, bubble_cnt
    );

    modport slave (
        input  d_valid, d_instr, d_PC, d_rs_data, d_rt_data, stall, flush, e_hold,
        output e_valid, e_A, e_B, e_PC, e_instr, e_ALUop, e_wreg, e_illegal, bubble_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// D->E issue stage for the E-stage ALU. Decodes the D-stage instruction into an
// ALU op code plus operands and registers them into E one cycle later. Stall,
// flush or an empty D slot insert a bubble; e_hold freezes E entirely. A
// saturating counter records how many bubbles were loaded into E.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    alu_issue_stage_if.slave (D inputs, hazard controls, E outputs)
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_issue_stage_if.slave     bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [31:0] ALU_ADD = 32'd0;
    localparam logic [31:0] ALU_SUB = 32'd1;
    localparam logic [31:0] ALU_OR  = 32'd2;
    localparam logic [31:0] ALU_LUI = 32'd3;
    localparam logic [31:0] ALU_PC8 = 32'd4;

    // Instruction fields
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [31:0] w_zimm;
    logic [31:0] w_simm;

    assign w_op    = bus.d_instr[31:26];
    assign w_funct = bus.d_instr[5:0];
    assign w_rt    = bus.d_instr[20:16];
    assign w_rd    = bus.d_instr[15:11];
    assign w_imm   = bus.d_instr[15:0];
    assign w_zimm  = {16'h0000, w_imm};
    assign w_simm  = {{16{w_imm[15]}}, w_imm};

    // Decoded fields
    logic [31:0] w_aluop;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_wreg;
    logic        w_illegal;
    logic        w_bubble;

    always_comb begin
        // NOTE: every decoded output gets a default before the case so that no
        // path leaves a value unassigned, which would otherwise infer a latch.
        w_aluop   = ALU_ADD;
        w_a       = '0;
        w_b       = '0;
        w_wreg    = '0;
        w_illegal = 1'b0;
        unique case (w_op)
            OP_RTYPE: begin
                unique case (w_funct)
                    FN_ADDU: begin
                        w_a    = bus.d_rs_data;
                        w_b    = bus.d_rt_data;
                        w_wreg = w_rd;
                    end
                    FN_SUBU: begin
                        w_aluop = ALU_SUB;
                        w_a     = bus.d_rs_data;
                        w_b     = bus.d_rt_data;
                        w_wreg  = w_rd;
                    end
                    // sll (and therefore nop) is issued as a harmless 0+0 with no write
                    FN_SLL:  ;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_ORI: begin
                w_aluop = ALU_OR;
                w_a     = bus.d_rs_data;
                w_b     = w_zimm;
                w_wreg  = w_rt;
            end
            OP_LUI: begin
                w_aluop = ALU_LUI;
                w_b     = w_zimm;
                w_wreg  = w_rt;
            end
            OP_LW: begin
                w_a    = bus.d_rs_data;
                w_b    = w_simm;
                w_wreg = w_rt;
            end
            OP_SW: begin
                w_a = bus.d_rs_data;
                w_b = w_simm;
            end
            OP_BEQ: begin
                w_aluop = ALU_SUB;
                w_a     = bus.d_rs_data;
                w_b     = bus.d_rt_data;
            end
            OP_JAL: begin
                w_aluop = ALU_PC8;
                w_wreg  = 5'd31;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // stall and flush together still produce exactly one bubble per cycle
    assign w_bubble = bus.stall | bus.flush | ~bus.d_valid;

    // E-stage registers
    logic             r_valid;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_aluop;
    logic [4:0]       r_wreg;
    logic             r_illegal;
    logic [CNT_W-1:0] r_bubble_cnt;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_aluop      <= '0;
            r_wreg       <= '0;
            r_illegal    <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (!bus.e_hold) begin
            if (w_bubble) begin
                r_valid   <= 1'b0;
                r_a       <= '0;
                r_b       <= '0;
                r_pc      <= RESET_PC;
                r_instr   <= '0;
                r_aluop   <= '0;
                r_wreg    <= '0;
                r_illegal <= 1'b0;
                if (r_bubble_cnt != {CNT_W{1'b1}}) begin
                    r_bubble_cnt <= r_bubble_cnt + 1'b1;
                end
            end else begin
                r_valid   <= 1'b1;
                r_a       <= w_a;
                r_b       <= w_b;
                r_pc      <= bus.d_PC;
                r_instr   <= bus.d_instr;
                r_aluop   <= w_aluop;
                r_wreg    <= w_wreg;
                r_illegal <= w_illegal;
            end
        end
    end

    assign bus.e_valid    = r_valid;
    assign bus.e_A        = r_a;
    assign bus.e_B        = r_b;
    assign bus.e_PC       = r_pc;
    assign bus.e_instr    = r_instr;
    assign bus.e_ALUop    = r_aluop;
    assign bus.e_wreg     = r_wreg;
    assign bus.e_illegal  = r_illegal;
    assign bus.bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Self-checking bench for alu_issue_stage. Each driven cycle pushes the
// expected E-stage contents onto a scoreboard queue; a monitor pops and
// compares one entry after every rising edge. Scenario tasks add targeted
// checks against literal values. A second instance with a 4-bit counter
// shares the same stimulus to exercise counter saturation quickly.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] aluop;
        logic [4:0]  wreg;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.CNT_W(16)) m_if ();
    alu_issue_stage_if #(.CNT_W(4))  s_if ();

    alu_issue_stage #(.CNT_W(16), .RESET_PC(RESET_PC)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if.slave)
    );

    alu_issue_stage #(.CNT_W(4), .RESET_PC(RESET_PC)) u_dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if.slave)
    );

    assign s_if.d_valid   = m_if.d_valid;
    assign s_if.d_instr   = m_if.d_instr;
    assign s_if.d_PC      = m_if.d_PC;
    assign s_if.d_rs_data = m_if.d_rs_data;
    assign s_if.d_rt_data = m_if.d_rt_data;
    assign s_if.stall     = m_if.stall;
    assign s_if.flush     = m_if.flush;
    assign s_if.e_hold    = m_if.e_hold;

    int checks   = 0;
    int failures = 0;

    exp_t        sb[$];
    exp_t        last_exp;
    logic [15:0] model_cnt;
    logic [3:0]  small_cnt;

    // Reference decode, written from the instruction table
    function automatic exp_t model_decode(input logic [31:0] instr,
                                          input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [31:0] z;
        logic [31:0] s;
        e = '0;
        z = {16'h0, instr[15:0]};
        s = {{16{instr[15]}}, instr[15:0]};
        case (instr[31:26])
            6'h00: begin
                if (instr[5:0] == 6'h21) begin
                    e.aluop = 0; e.a = rs; e.b = rt; e.wreg = instr[15:11];
                end else if (instr[5:0] == 6'h23) begin
                    e.aluop = 1; e.a = rs; e.b = rt; e.wreg = instr[15:11];
                end else if (instr[5:0] != 6'h00) begin
                    e.ill = 1'b1;
                end
            end
            6'h0D: begin e.aluop = 2; e.a = rs; e.b = z; e.wreg = instr[20:16]; end
            6'h0F: begin e.aluop = 3; e.b = z; e.wreg = instr[20:16]; end
            6'h23: begin e.aluop = 0; e.a = rs; e.b = s; e.wreg = instr[20:16]; end
            6'h2B: begin e.aluop = 0; e.a = rs; e.b = s; end
            6'h04: begin e.aluop = 1; e.a = rs; e.b = rt; end
            6'h03: begin e.aluop = 4; e.wreg = 5'd31; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Drive one cycle at the falling edge, record the expectation, and return
    // shortly after the following rising edge.
    task automatic cycle(input logic rst_n, input logic valid, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                         input logic stl, input logic fls, input logic hld);
        exp_t e;
        @(negedge clk);
        reset          = rst_n;
        m_if.d_valid   = valid;
        m_if.d_instr   = instr;
        m_if.d_PC      = pc;
        m_if.d_rs_data = rs;
        m_if.d_rt_data = rt;
        m_if.stall     = stl;
        m_if.flush     = fls;
        m_if.e_hold    = hld;
        if (!rst_n) begin
            model_cnt = '0;
            small_cnt = '0;
            e         = '0;
            e.pc      = RESET_PC;
        end else if (hld) begin
            e = last_exp;
        end else if (stl || fls || !valid) begin
            if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
            if (small_cnt != 4'hF)     small_cnt = small_cnt + 4'd1;
            e       = '0;
            e.pc    = RESET_PC;
            e.cnt   = model_cnt;
        end else begin
            e       = model_decode(instr, rs, rt);
            e.valid = 1'b1;
            e.pc    = pc;
            e.instr = instr;
            e.cnt   = model_cnt;
        end
        last_exp = e;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: one full-slot comparison per edge with a pending entry
    exp_t mon_exp;
    exp_t mon_act;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_act = {m_if.e_valid, m_if.e_A, m_if.e_B, m_if.e_PC, m_if.e_instr,
                       m_if.e_ALUop, m_if.e_wreg, m_if.e_illegal, m_if.bubble_cnt};
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL sb_slot t=%0t actual=%h required=%h", $time, mon_act, mon_exp);
            end
        end
    end

    task automatic test_reset();
        cycle(0, 1, 32'h0022_1821, 32'h3004, 5, 7, 0, 0, 0);
        cycle(0, 1, 32'h0022_1821, 32'h3004, 5, 7, 0, 0, 0);
        checks++;
        if (m_if.e_PC !== 32'h3000) begin
            failures++; $display("FAIL reset_pc actual=%h required=%h", m_if.e_PC, 32'h3000);
        end
        checks++;
        if ({m_if.e_valid, m_if.e_wreg, m_if.e_instr} !== 38'd0) begin
            failures++; $display("FAIL reset_slot actual=%b/%0d/%h required=0", m_if.e_valid, m_if.e_wreg, m_if.e_instr);
        end
        checks++;
        if (m_if.bubble_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_cnt actual=%0d required=0", m_if.bubble_cnt);
        end
    endtask

    task automatic test_decode();
        cycle(1, 1, 32'h0022_1821, 32'h3004, 5, 7, 0, 0, 0);      // addu $3,$1,$2
        checks++;
        if ({m_if.e_valid, m_if.e_ALUop, m_if.e_A, m_if.e_B, m_if.e_wreg, m_if.e_PC} !==
            {1'b1, 32'd0, 32'd5, 32'd7, 5'd3, 32'h3004}) begin
            failures++;
            $display("FAIL addu actual=v%b op%0d A%0d B%0d w%0d pc%h required=v1 op0 A5 B7 w3 pc3004",
                     m_if.e_valid, m_if.e_ALUop, m_if.e_A, m_if.e_B, m_if.e_wreg, m_if.e_PC);
        end
        cycle(1, 1, 32'h8C24_FFFC, 32'h3008, 32'h100, 0, 0, 0, 0); // lw $4,-4($1)
        checks++;
        if (m_if.e_B !== 32'hFFFF_FFFC || m_if.e_wreg !== 5'd4) begin
            failures++; $display("FAIL lw_sext actual=B%h w%0d required=Bfffffffc w4", m_if.e_B, m_if.e_wreg);
        end
        cycle(1, 1, 32'h3C05_1234, 32'h300C, 9, 9, 0, 0, 0);      // lui $5,0x1234
        checks++;
        if (m_if.e_ALUop !== 32'd3 || m_if.e_B !== 32'h0000_1234 || m_if.e_A !== 32'd0) begin
            failures++; $display("FAIL lui actual=op%0d B%h A%h required=op3 B00001234 A0", m_if.e_ALUop, m_if.e_B, m_if.e_A);
        end
        cycle(1, 1, 32'h0C00_0C04, 32'h3010, 1, 2, 0, 0, 0);      // jal
        checks++;
        if (m_if.e_ALUop !== 32'd4 || m_if.e_PC !== 32'h3010 || m_if.e_wreg !== 5'd31) begin
            failures++; $display("FAIL jal actual=op%0d pc%h w%0d required=op4 pc3010 w31", m_if.e_ALUop, m_if.e_PC, m_if.e_wreg);
        end
        cycle(1, 1, 32'h0022_3023, 32'h3014, 20, 3, 0, 0, 0);     // subu $6,$1,$2
        cycle(1, 1, 32'h3427_8001, 32'h3018, 4, 0, 0, 0, 0);      // ori $7,$1,0x8001
        checks++;
        if (m_if.e_B !== 32'h0000_8001 || m_if.e_ALUop !== 32'd2 || m_if.e_wreg !== 5'd7) begin
            failures++; $display("FAIL ori_zext actual=B%h op%0d w%0d required=B00008001 op2 w7", m_if.e_B, m_if.e_ALUop, m_if.e_wreg);
        end
        cycle(1, 1, 32'h1022_0003, 32'h301C, 8, 8, 0, 0, 0);      // beq
        cycle(1, 1, 32'hAC22_FFF8, 32'h3020, 64, 1, 0, 0, 0);     // sw
        checks++;
        if (m_if.e_wreg !== 5'd0 || m_if.e_B !== 32'hFFFF_FFF8) begin
            failures++; $display("FAIL sw actual=w%0d B%h required=w0 Bfffffff8", m_if.e_wreg, m_if.e_B);
        end
        cycle(1, 1, 32'h0000_0000, 32'h3024, 3, 4, 0, 0, 0);      // nop
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h0022_1821, 32'h3028, 1, 1, 1, 0, 0);
        cycle(1, 1, 32'h0022_1821, 32'h3028, 1, 1, 1, 1, 0);
        checks++;
        if (m_if.bubble_cnt !== 16'd4 || m_if.e_valid !== 1'b0 || m_if.e_PC !== RESET_PC) begin
            failures++; $display("FAIL bubbles actual=cnt%0d v%b pc%h required=cnt4 v0 pc3000", m_if.bubble_cnt, m_if.e_valid, m_if.e_PC);
        end
    endtask

    task automatic test_hold();
        cycle(1, 1, 32'h3427_00F0, 32'h3030, 32'h0F, 0, 0, 0, 0); // ori $7,$1,0xF0
        for (int i = 0; i < 2; i++) cycle(1, 1, 32'h0022_3023, 32'h3034, 2, 2, 1, 1, 1);
        checks++;
        if (m_if.e_instr !== 32'h3427_00F0 || m_if.e_valid !== 1'b1 || m_if.e_PC !== 32'h3030) begin
            failures++; $display("FAIL hold_slot actual=i%h v%b pc%h required=i342700f0 v1 pc3030", m_if.e_instr, m_if.e_valid, m_if.e_PC);
        end
        checks++;
        if (m_if.bubble_cnt !== 16'd4) begin
            failures++; $display("FAIL hold_cnt actual=%0d required=4", m_if.bubble_cnt);
        end
        cycle(1, 0, 32'h0022_1821, 32'h3038, 1, 1, 0, 0, 0);       // empty D slot
        checks++;
        if (m_if.bubble_cnt !== 16'd5 || m_if.e_valid !== 1'b0) begin
            failures++; $display("FAIL invalid_bubble actual=cnt%0d v%b required=cnt5 v0", m_if.bubble_cnt, m_if.e_valid);
        end
    endtask

    task automatic test_illegal();
        cycle(1, 1, 32'hFC22_1821, 32'h3040, 1, 2, 0, 0, 0);       // opcode 0x3F
        checks++;
        if ({m_if.e_valid, m_if.e_illegal, m_if.e_wreg} !== {1'b1, 1'b1, 5'd0}) begin
            failures++; $display("FAIL illegal_op actual=v%b ill%b w%0d required=v1 ill1 w0", m_if.e_valid, m_if.e_illegal, m_if.e_wreg);
        end
        cycle(1, 1, 32'h0022_183F, 32'h3044, 1, 2, 0, 0, 0);       // R-type funct 0x3F
        checks++;
        if (m_if.e_illegal !== 1'b1 || m_if.e_wreg !== 5'd0) begin
            failures++; $display("FAIL illegal_funct actual=ill%b w%0d required=ill1 w0", m_if.e_illegal, m_if.e_wreg);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) cycle(1, 1, 32'h0, 32'h3048, 0, 0, 1, 0, 0);
        checks++;
        if (s_if.bubble_cnt !== 4'hF || s_if.bubble_cnt !== small_cnt) begin
            failures++; $display("FAIL sat_small actual=%h required=f", s_if.bubble_cnt);
        end
        cycle(1, 1, 32'h0, 32'h3048, 0, 0, 0, 1, 0);
        checks++;
        if (s_if.bubble_cnt !== 4'hF) begin
            failures++; $display("FAIL sat_hold actual=%h required=f", s_if.bubble_cnt);
        end
        checks++;
        if (m_if.bubble_cnt !== 16'd26) begin
            failures++; $display("FAIL cnt_after_sat actual=%0d required=26", m_if.bubble_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tbl[8];
        tbl = '{32'h0022_1821, 32'h0022_3023, 32'h3427_8001, 32'h3C05_1234,
                32'h8C24_FFFC, 32'hAC22_0010, 32'h1022_0003, 32'h0C00_0C04};
        for (int i = 0; i < 40; i++) begin
            cycle(1, ($urandom_range(7) != 0), tbl[$urandom_range(7)], 32'h3100 + 4 * i,
                  $urandom, $urandom, ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(7) == 0));
        end
    endtask

    initial begin
        reset          = 1'b0;
        m_if.d_valid   = 1'b0;
        m_if.d_instr   = '0;
        m_if.d_PC      = '0;
        m_if.d_rs_data = '0;
        m_if.d_rt_data = '0;
        m_if.stall     = 1'b0;
        m_if.flush     = 1'b0;
        m_if.e_hold    = 1'b0;
        model_cnt      = '0;
        small_cnt      = '0;
        last_exp       = '0;

        test_reset();
        test_decode();
        test_bubbles();
        test_hold();
        test_illegal();
        test_saturation();
        test_back_to_back();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
